// File: rtl/spi_bridge_pkg.sv
// rtl/spi_bridge_pkg.sv - FSM states, direction codes and GAP limits for the SPI bridge initiator
package spi_bridge_pkg;

   // Transaction phases: header (START, ADDR, DIR), payload (DATA, WAIT_WR),
   // inter-pulse spacing (GAP) and framing end (STOP).
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_DIR,
      S_DATA,
      S_WAIT_WR,
      S_GAP,
      S_STOP
   } state_t;

   // Direction byte sent after the address bytes.
   localparam logic [7:0] DIR_WRITE = 8'h01;
   localparam logic [7:0] DIR_READ  = 8'h00;

   // Legal range for the idle spacing between spi_next pulses.
   localparam int GAP_MIN = 3;
   localparam int GAP_MAX = 15;

endpackage

// File: rtl/spi_bridge_initiator.sv
// rtl/spi_bridge_initiator.sv - command-driven byte framer toward an SPI bridge
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_write, cmd_addr, cmd_len)
//   wr_valid/wr_ready/wr_data     write payload byte stream
//   rd_valid/rd_data              read payload byte stream, one-cycle pulse per byte
//   spi_start/spi_next/spi_stop   byte framing toward the bridge
//   to_bridge                     byte driven with spi_next, 0x00 otherwise
//   from_bridge                   byte returned by the bridge in the spi_next cycle
//   busy, done                    transaction in progress, completion pulse
module spi_bridge_initiator
   import spi_bridge_pkg::*;
#(
   parameter int ADDR_BYTES = 2,
   parameter int GAP        = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_BYTES*8-1:0] cmd_addr,
   input  logic [7:0]              cmd_len,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [7:0]              wr_data,
   output logic                    rd_valid,
   output logic [7:0]              rd_data,
   output logic                    spi_start,
   output logic                    spi_next,
   output logic                    spi_stop,
   output logic [7:0]              to_bridge,
   input  logic [7:0]              from_bridge,
   output logic                    busy,
   output logic                    done
);

   // addr_idx walks 0..ADDR_BYTES-1 through the address bytes; IDX_DIR means
   // the direction byte is next, IDX_DATA means the header has been sent.
   localparam int               IDX_W    = $clog2(ADDR_BYTES + 2);
   localparam logic [IDX_W-1:0] IDX_DIR  = IDX_W'(ADDR_BYTES);
   localparam logic [IDX_W-1:0] IDX_DATA = IDX_W'(ADDR_BYTES + 1);
   localparam logic [3:0]       GAP_LOAD = 4'(GAP - 1);

   generate
      if (GAP < GAP_MIN || GAP > GAP_MAX) begin : g_bad_gap
         $error("spi_bridge_initiator: GAP out of range");
      end
   endgenerate

   state_t                  state;
   logic [3:0]              gap_cnt;
   logic [7:0]              byte_cnt;
   logic [IDX_W-1:0]        addr_idx;
   logic                    write_q;
   logic [ADDR_BYTES*8-1:0] addr_q;
   logic [7:0]              len_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         gap_cnt   <= 4'd0;
         byte_cnt  <= 8'd0;
         addr_idx  <= '0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         len_q     <= 8'd0;
         cmd_ready <= 1'b0;
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= 8'd0;
         spi_start <= 1'b0;
         spi_next  <= 1'b0;
         spi_stop  <= 1'b0;
         to_bridge <= 8'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         // Every strobe is a single-cycle pulse; only the state that issues
         // one raises it again.
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= 8'd0;
         spi_start <= 1'b0;
         spi_next  <= 1'b0;
         spi_stop  <= 1'b0;
         to_bridge <= 8'd0;
         done      <= 1'b0;

         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_ready && cmd_valid) begin
                  write_q   <= cmd_write;
                  addr_q    <= cmd_addr;
                  len_q     <= cmd_len;
                  addr_idx  <= '0;
                  // A read gets its first byte back on the DIR pulse, so it
                  // needs one data pulse fewer than its length.
                  byte_cnt  <= (cmd_write || cmd_len == 8'd0) ? cmd_len : cmd_len - 8'd1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  spi_start <= 1'b1;
                  state     <= S_START;
               end
            end

            S_START: begin
               gap_cnt <= GAP_LOAD;
               state   <= S_GAP;
            end

            S_ADDR: begin
               gap_cnt <= GAP_LOAD;
               state   <= S_GAP;
            end

            S_DIR: begin
               // Byte returned on a write's DIR pulse is dropped.
               if (!write_q && len_q != 8'd0) begin
                  rd_valid <= 1'b1;
                  rd_data  <= from_bridge;
               end
               gap_cnt <= GAP_LOAD;
               state   <= S_GAP;
            end

            S_DATA: begin
               if (!write_q) begin
                  rd_valid <= 1'b1;
                  rd_data  <= from_bridge;
               end
               gap_cnt <= GAP_LOAD;
               state   <= S_GAP;
            end

            S_WAIT_WR: begin
               // The source had nothing when the byte fell due; the pulse
               // follows the first cycle in which it offers one.
               if (wr_valid) begin
                  spi_next  <= 1'b1;
                  to_bridge <= wr_data;
                  wr_ready  <= 1'b1;
                  byte_cnt  <= byte_cnt - 8'd1;
                  state     <= S_DATA;
               end
            end

            S_GAP: begin
               if (gap_cnt != 4'd0) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end else if (addr_idx < IDX_DIR) begin
                  spi_next  <= 1'b1;
                  to_bridge <= addr_q[8*int'(addr_idx) +: 8];
                  addr_idx  <= addr_idx + 1'b1;
                  state     <= S_ADDR;
               end else if (addr_idx == IDX_DIR) begin
                  spi_next  <= 1'b1;
                  to_bridge <= write_q ? DIR_WRITE : DIR_READ;
                  addr_idx  <= IDX_DATA;
                  state     <= S_DIR;
               end else if (byte_cnt == 8'd0) begin
                  spi_stop <= 1'b1;
                  done     <= 1'b1;
                  state    <= S_STOP;
               end else if (!write_q) begin
                  spi_next <= 1'b1;
                  byte_cnt <= byte_cnt - 8'd1;
                  state    <= S_DATA;
               end else if (wr_valid) begin
                  spi_next  <= 1'b1;
                  to_bridge <= wr_data;
                  wr_ready  <= 1'b1;
                  byte_cnt  <= byte_cnt - 8'd1;
                  state     <= S_DATA;
               end else begin
                  state <= S_WAIT_WR;
               end
            end

            S_STOP: begin
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_bridge_initiator.md
SPI_BRIDGE_INITIATOR -- requirements
Module: spi_bridge_initiator

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 2, the number of address bytes sent per transaction.
REQ-002 SHALL have parameter GAP, default 3, the idle cycles between consecutive spi_next pulses (legal range 3..15).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 cmd_valid  input  1  transaction request.
REQ-006 cmd_ready  output  1  request accepted when high together with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_BYTES*8  start address.
REQ-009 cmd_len  input  8  data byte count, 0..255.
REQ-010 wr_valid / wr_ready / wr_data  input / output / input  1/1/8  write-data byte stream.
REQ-011 rd_valid / rd_data  output / output  1/8  read-data byte stream, one-cycle valid pulse, no back-pressure.
REQ-012 spi_start / spi_next / spi_stop  output  1 each  byte-level framing toward the bridge.
REQ-013 to_bridge  output  8  byte presented with spi_next.
REQ-014 from_bridge  input  8  byte returned by the bridge, valid in the spi_next cycle.
REQ-015 busy  output  1  high from acceptance until the stop pulse; done  output  1  one-cycle pulse with spi_stop.

Function
REQ-016 SHALL use FSM states IDLE, START, ADDR, DIR, DATA, WAIT_WR, GAP, STOP.
REQ-017 cmd_ready SHALL be high only in IDLE; acceptance SHALL latch cmd_write, cmd_addr and cmd_len and move to START.
REQ-018 START SHALL assert spi_start for exactly one cycle, then enter GAP before the first byte.
REQ-019 ADDR SHALL send ADDR_BYTES bytes, LSB first, one spi_next pulse each.
REQ-020 DIR SHALL send 0x01 for a write and 0x00 for a read.
REQ-021 Each spi_next SHALL be one cycle wide, with to_bridge valid in that cycle and 0x00 otherwise.
REQ-022 Consecutive spi_next pulses SHALL be separated by exactly GAP low cycles, except when stretched by WAIT_WR.
REQ-023 Write, byte slots:
 - SHALL issue cmd_len data pulses after DIR.
 - Each pulse SHALL carry one wr_data byte.
 - wr_ready SHALL be high for exactly one cycle per byte, in the spi_next cycle.
REQ-024 Write, underflow: if wr_valid is low when a byte is due, SHALL hold in WAIT_WR with no pulse, then issue the byte in the cycle wr_valid is seen.
REQ-025 Read, captures:
 - from_bridge in the DIR pulse cycle SHALL be captured as data byte 0.
 - cmd_len-1 further pulses SHALL follow, each sending 0x00 and capturing one byte.
REQ-026 Captured bytes SHALL appear on rd_data with rd_valid high on the cycle after their spi_next.
REQ-027 Bytes returned during ADDR pulses, and during the DIR pulse of a write, SHALL be discarded.
REQ-028 Length 0:
 - header (ADDR bytes plus DIR) SHALL still be sent, then stop.
 - a read SHALL produce no rd_valid.
REQ-029 Length and counting:
 - cmd_len=1 read SHALL issue no data-phase pulses.
 - the byte counter SHALL be 8 bits and never wrap within a transaction.
REQ-030 STOP SHALL assert spi_stop and done for one cycle, GAP cycles after the last pulse, then return to IDLE.
REQ-031 Latched cmd_* SHALL stay stable for the whole transaction; cmd_valid during busy SHALL be ignored.

Reset
REQ-032 With rst low at a clock edge, every output SHALL be 0 on the following cycle and the FSM SHALL be IDLE (cmd_ready=1 after release).
REQ-033 Reset mid-transaction SHALL abort with no spi_stop, done or rd_valid emitted.

Structure
REQ-034 Package spi_bridge_pkg SHALL hold:
 - the FSM state enum;
 - constants DIR_WRITE=8'h01 and DIR_READ=8'h00;
 - GAP range limits.
REQ-035 Single module; no sub-module: FSM plus a 4-bit gap counter, an 8-bit byte counter and an address-byte index.

Verification
REQ-036 Write addr 0x1234, len 3, data A5 5A 3C, wr_valid always high -> spi_start, then to_bridge sequence 34 12 01 A5 5A 3C, 3 GAP cycles between pulses, spi_stop and done, 3 wr_ready pulses.
REQ-037 Read addr 0x00FF, len 4, bridge returns 11 22 33 44 from the DIR pulse onward -> to_bridge FF 00 00 00 00 00, rd_data 11 22 33 44 each one cycle after its pulse.
REQ-038 Write len 2 with wr_valid withheld 10 cycles before byte 2 -> second data pulse delayed 10 cycles, no extra pulses, correct byte.
REQ-039 Read len 0 and read len 1 -> header only (3 pulses) with 0 rd_valid, and 3 pulses with 1 rd_valid.
REQ-040 Reset asserted during DATA of a len-8 read -> outputs 0 on the next cycle, no spi_stop, next command runs normally.
REQ-041 cmd_valid held high across two back-to-back commands -> second accepted only after done, with cmd_ready low throughout busy.
